// File: rtl/bt_stream_tx_scheduler.sv
// Round-robin framer sharing one UART transmitter among stream FIFOs: header {A,id} then payload bytes.
// Grant-to-uart_start one cycle; each byte waits for uart_done, then spacing_limit idle cycles per packet.
module bt_stream_tx_scheduler #(
    parameter int NUM_STREAMS   = 4,
    parameter int PAYLOAD_BYTES = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [9:0]               spacing_limit_i,
    input  logic [NUM_STREAMS-1:0]   stream_ready_i,
    input  logic [8*NUM_STREAMS-1:0] stream_data_i,
    output logic [NUM_STREAMS-1:0]   stream_pop_o,
    output logic                     uart_start_o,
    output logic [7:0]               uart_byte_o,
    input  logic                     uart_done_i,
    output logic [3:0]               grant_id_o,
    output logic                     busy_o,
    output logic [15:0]              packets_sent_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_HDR, S_WAIT_BYTE, S_GAP} state_t;

    localparam logic [3:0] LAST_INIT = 4'(NUM_STREAMS - 1);
    localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

    state_t                 state_q, state_d;
    logic [3:0]             grant_q, grant_d;
    logic [3:0]             last_q, last_d;
    logic [7:0]             byte_cnt_q, byte_cnt_d;
    logic [9:0]             gap_cnt_q, gap_cnt_d;
    logic                   uart_start_q, uart_start_d;
    logic [7:0]             uart_byte_q, uart_byte_d;
    logic [NUM_STREAMS-1:0] pop_q, pop_d;
    logic [15:0]            pkts_q, pkts_d;
    logic                   busy_q;

    logic [15:0]  ready_ext;
    logic [127:0] data_ext;
    logic [7:0]   head_dat;
    logic         done_vld;
    logic         pick_vld;
    logic [3:0]   pick_id;
    logic [4:0]   cand;

    assign ready_ext = 16'(stream_ready_i);
    assign data_ext  = 128'(stream_data_i);
    assign head_dat  = data_ext[{grant_q, 3'b000} +: 8];
    // A done that lands while start is still high cannot belong to the byte just launched.
    assign done_vld  = uart_done_i && !uart_start_q;

    // Scan from farthest to nearest so the stream closest after last_q wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = NUM_STREAMS; k >= 1; k--) begin
            cand = 5'(int'(last_q) + k);
            if (cand >= 5'(NUM_STREAMS)) begin
                cand = cand - 5'(NUM_STREAMS);
            end
            if (ready_ext[cand[3:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand[3:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        byte_cnt_d   = byte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        uart_start_d = 1'b0;
        uart_byte_d  = uart_byte_q;
        pop_d        = '0;
        pkts_d       = pkts_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i && pick_vld) begin
                    grant_d      = pick_id;
                    last_d       = pick_id;
                    uart_byte_d  = {4'hA, pick_id};
                    uart_start_d = 1'b1;
                    byte_cnt_d   = '0;
                    state_d      = S_WAIT_HDR;
                end
            end
            S_WAIT_HDR: begin
                if (done_vld) begin
                    uart_byte_d  = head_dat;
                    uart_start_d = 1'b1;
                    pop_d        = NUM_STREAMS'(16'd1 << grant_q);
                    state_d      = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                if (done_vld) begin
                    if (byte_cnt_q < LAST_BYTE) begin
                        byte_cnt_d   = byte_cnt_q + 8'd1;
                        uart_byte_d  = head_dat;
                        uart_start_d = 1'b1;
                        pop_d        = NUM_STREAMS'(16'd1 << grant_q);
                    end else begin
                        pkts_d    = pkts_q + 16'd1;
                        gap_cnt_d = '0;
                        state_d   = (spacing_limit_i != 10'd0) ? S_GAP : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 10'd1;
                // >= rather than == so a limit lowered mid-gap still releases the transmitter.
                if (({1'b0, gap_cnt_q} + 11'd1) >= {1'b0, spacing_limit_i}) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_q       <= LAST_INIT;
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            uart_start_q <= 1'b0;
            uart_byte_q  <= '0;
            pop_q        <= '0;
            pkts_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            uart_start_q <= uart_start_d;
            uart_byte_q  <= uart_byte_d;
            pop_q        <= pop_d;
            pkts_q       <= pkts_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign stream_pop_o   = pop_q;
    assign uart_start_o   = uart_start_q;
    assign uart_byte_o    = uart_byte_q;
    assign grant_id_o     = grant_q;
    assign busy_o         = busy_q;
    assign packets_sent_o = pkts_q;

endmodule
